// File: rtl/clock_select_pkg.sv
// Shared types and default configuration for the clock-select controller.
package clock_select_pkg;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ASSERT,
        WAIT_RELEASE,
        SETTLE
    } state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single level signal crossing into i_clk.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // NOTE: flops clear to 0 so the FSM sees the mux as "in reset" until the
    // real level has propagated through every stage after RST drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clock_select_ctrl.sv
// Sequences a glitch-free clock-mux switch: load select, wait for the mux reset
// to assert and release, then settle. Define CLKSEL_WATCHDOG_EN for the wait-state watchdog.
module clock_select_ctrl
    import clock_select_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    input  logic       REQ_SEL,
    output logic       REQ_READY,
    output logic       SELECT,
    output logic       SELECT_ENABLE,
    input  logic       SEL_RST_N,
    output logic       DONE,
    output logic       BUSY,
    output logic [7:0] SWITCH_COUNT,
    output logic       TIMEOUT
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be in 2..4");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle_cycles
        $error("SETTLE_CYCLES must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic       r_select;
    logic       r_select_en;
    logic       r_done;
    logic [7:0] r_switch_count;
    logic [7:0] r_settle_cnt;
    logic       w_mux_rst_n;

`ifdef CLKSEL_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;
    logic        r_timeout;
`endif

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sel_rst_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (SEL_RST_N),
        .o_q   (w_mux_rst_n)
    );

    // NOTE: all state is assigned with <= so every branch reads the
    // pre-edge values and the strobes default low each cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= IDLE;
            r_select       <= 1'b0;
            r_select_en    <= 1'b0;
            r_done         <= 1'b0;
            r_switch_count <= 8'd0;
            r_settle_cnt   <= 8'd0;
`ifdef CLKSEL_WATCHDOG_EN
            r_wdog         <= 16'd0;
            r_timeout      <= 1'b0;
`endif
        end else begin
            r_select_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (REQ_VALID) begin
`ifdef CLKSEL_WATCHDOG_EN
                        r_timeout <= 1'b0;
`endif
                        if (REQ_SEL == r_select) begin
                            r_done <= 1'b1;
                        end else begin
                            r_select    <= REQ_SEL;
                            r_select_en <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT_ASSERT;
`ifdef CLKSEL_WATCHDOG_EN
                    r_wdog  <= 16'd0;
`endif
                end
                WAIT_ASSERT: begin
                    if (!w_mux_rst_n) begin
                        r_state <= WAIT_RELEASE;
`ifdef CLKSEL_WATCHDOG_EN
                        r_wdog  <= 16'd0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
`endif
                    end
                end
                WAIT_RELEASE: begin
                    if (w_mux_rst_n) begin
                        r_state      <= SETTLE;
                        r_settle_cnt <= 8'd0;
`ifdef CLKSEL_WATCHDOG_EN
                    end else if (r_wdog == WDOG_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
`endif
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state        <= IDLE;
                        r_done         <= 1'b1;
                        r_switch_count <= r_switch_count + 8'd1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign REQ_READY     = (r_state == IDLE);
    assign BUSY          = (r_state != IDLE);
    assign SELECT        = r_select;
    assign SELECT_ENABLE = r_select_en;
    assign DONE          = r_done;
    assign SWITCH_COUNT  = r_switch_count;

`ifdef CLKSEL_WATCHDOG_EN
    assign TIMEOUT = r_timeout;
`else
    assign TIMEOUT = 1'b0;
`endif

endmodule
